// File: rtl/gs232c_dec_free_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gs232c_dec_free_n_pkg
// Description : Constants shared by the free-list tracker and the first-one
//               encoder: entry-count expression and supported index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package gs232c_dec_free_n_pkg;

  localparam int c_N_MIN = 1;
  localparam int c_N_MAX = 3;

  // Number of entries addressed by an n-bit encoded index.
  function automatic int entries(input int n);
    return 1 << n;
  endfunction

  // True when n lies in the supported index-width range.
  function automatic bit n_supported(input int n);
    return (n >= c_N_MIN) && (n <= c_N_MAX);
  endfunction

endpackage : gs232c_dec_free_n_pkg
`default_nettype wire

// File: rtl/gs232c_dec_n_m.sv
`default_nettype none
// ============================================================================
// Module      : gs232c_dec_n_m
// Description : Combinational binary-to-one-hot decoder gated by a valid.
//               An invalid input yields an all-zero vector.
// Revision    : 1.0 - initial release
// ============================================================================
module gs232c_dec_n_m
  import gs232c_dec_free_n_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                v,
  input  logic [N-1:0]        i,
  output logic [(1<<N)-1:0]   o
);

  // Set only the addressed bit, and only when the port is valid.
  always_comb begin
    o = '0;
    if (v) begin
      o[i] = 1'b1;
    end
  end

endmodule : gs232c_dec_n_m
`default_nettype wire

// File: rtl/gs232c_dec_free_n.sv
`default_nettype none
// ============================================================================
// Module      : gs232c_dec_free_n
// Description : Entry free-list tracker. Decodes one allocation and two
//               release indices, keeps a registered busy vector, publishes
//               free_mask / free_cnt / full and flags protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module gs232c_dec_free_n
  import gs232c_dec_free_n_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic [N-1:0]          alloc_idx,
  input  logic                  rel0_valid,
  input  logic [N-1:0]          rel0_idx,
  input  logic                  rel1_valid,
  input  logic [N-1:0]          rel1_idx,
  output logic [(1<<N)-1:0]     free_mask,
  output logic [N:0]            free_cnt,
  output logic                  full,
  output logic                  err_dbl_free,
  output logic                  err_alloc_busy
);

  localparam int               c_E        = entries(N);
  localparam logic [N:0]       c_ALL_FREE = c_E[N:0];

  generate
    if (!n_supported(N)) begin : g_bad_n
      $error("gs232c_dec_free_n: N must be in 1..3");
    end
  endgenerate

  logic [c_E-1:0] r_busy;
  logic [N:0]     r_free_cnt;
  logic           r_full;
  logic           r_err_dbl_free;
  logic           r_err_alloc_busy;

  logic [c_E-1:0] w_a_oh;
  logic [c_E-1:0] w_r0_oh;
  logic [c_E-1:0] w_r1_oh;
  logic [c_E-1:0] w_b1;
  logic [c_E-1:0] w_next_busy;
  logic [N:0]     w_next_cnt;
  logic           w_dbl_free;
  logic           w_alloc_busy;

  gs232c_dec_n_m #(.N(N)) u_dec_alloc (
    .v (alloc_valid),
    .i (alloc_idx),
    .o (w_a_oh)
  );

  gs232c_dec_n_m #(.N(N)) u_dec_rel0 (
    .v (rel0_valid),
    .i (rel0_idx),
    .o (w_r0_oh)
  );

  gs232c_dec_n_m #(.N(N)) u_dec_rel1 (
    .v (rel1_valid),
    .i (rel1_idx),
    .o (w_r1_oh)
  );

  // Release before allocate so an entry can be recycled in one cycle; flush wins.
  always_comb begin
    w_b1        = r_busy & ~(w_r0_oh | w_r1_oh);
    w_next_busy = flush ? '0 : (w_b1 | w_a_oh);
  end

  // Popcount of the next free vector; N+1 bits holds the all-free value.
  always_comb begin
    w_next_cnt = '0;
    for (int k = 0; k < c_E; k++) begin
      w_next_cnt = w_next_cnt + {{N{1'b0}}, ~w_next_busy[k]};
    end
  end

  // Violation detection against the current busy vector; suppressed by flush.
  always_comb begin
    w_dbl_free   = 1'b0;
    w_alloc_busy = 1'b0;
    if (!flush) begin
      w_dbl_free = (|(w_r0_oh & ~r_busy)) ||
                   (|(w_r1_oh & ~r_busy)) ||
                   (rel0_valid && rel1_valid && (rel0_idx == rel1_idx));
      w_alloc_busy = |(w_a_oh & w_b1);
    end
  end

  // State and published outputs, all updated together with one-cycle latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy           <= '0;
      r_free_cnt       <= c_ALL_FREE;
      r_full           <= 1'b0;
      r_err_dbl_free   <= 1'b0;
      r_err_alloc_busy <= 1'b0;
    end else begin
      r_busy           <= w_next_busy;
      r_free_cnt       <= w_next_cnt;
      r_full           <= (w_next_cnt == '0);
      r_err_dbl_free   <= w_dbl_free;
      r_err_alloc_busy <= w_alloc_busy;
    end
  end

  assign free_mask      = ~r_busy;
  assign free_cnt       = r_free_cnt;
  assign full           = r_full;
  assign err_dbl_free   = r_err_dbl_free;
  assign err_alloc_busy = r_err_alloc_busy;

endmodule : gs232c_dec_free_n
`default_nettype wire
